// File: rtl/dht11_pkg.sv
// DHT11 controller shared definitions.
//   - FSM state encoding
//   - frame / data widths
//   - default timing parameters (microseconds) and clock frequency
//   - checksum helper used by the CHECK state
package dht11_pkg;

    localparam int FRAME_W   = 40;
    localparam int DATA_W    = 32;
    localparam int BIT_CNT_W = 6;

    localparam int DEF_CLK_HZ        = 100_000_000;
    localparam int DEF_START_LOW_US  = 18_000;
    localparam int DEF_RELEASE_US    = 30;
    localparam int DEF_BIT_THRESH_US = 40;
    localparam int DEF_TIMEOUT_US    = 1_000;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_START_LOW,
        ST_RELEASE,
        ST_WAIT_RESP_LOW,
        ST_WAIT_RESP_HIGH,
        ST_WAIT_RESP_END,
        ST_WAIT_BIT_HIGH,
        ST_MEASURE,
        ST_CHECK
    } state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Low byte must equal the 8-bit wrap-around sum of the four data bytes.
    function automatic logic checksum_ok(input logic [FRAME_W-1:0] frame);
        logic [7:0] sum;
        sum = frame[39:32] + frame[31:24] + frame[23:16] + frame[15:8];
        return (sum == frame[7:0]);
    endfunction

endpackage

// File: rtl/dht11_controller_tick_gen.sv
// tick_gen_us: free-running 1 us tick generator.
// Ports:
//   clk_i    system clock
//   rst_ni   synchronous active-low reset
//   tick_o   one-cycle pulse every CLK_HZ/1_000_000 clock cycles
module tick_gen_us
    import dht11_pkg::*;
#(
    parameter int CLK_HZ = DEF_CLK_HZ
) (
    input  logic clk_i,
    input  logic rst_ni,
    output logic tick_o
);

    // A divider of 1 (1 MHz clock) degenerates to a tick on every cycle.
    localparam int DIV = (CLK_HZ / 1_000_000 > 1) ? (CLK_HZ / 1_000_000) : 1;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
            cnt_d = RELOAD;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= RELOAD;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == '0);

endmodule

// File: rtl/dht11_controller.sv
// dht11_controller: single-wire DHT11 host. Issues the start pulse, captures
// the 40-bit sensor frame, verifies the checksum and publishes a 32-bit word
// {hum_int, hum_dec, temp_int, temp_dec}.
// Ports:
//   clk       system clock
//   reset     synchronous active-low reset
//   start     level request, accepted only in IDLE
//   dht_io    open-drain sensor line (driven 0 or released)
//   dht_data  last good frame payload
//   valid     one-cycle pulse when dht_data updates
//   busy      FSM not in IDLE
//   error     timeout / checksum failure, cleared by the next accepted start
//
// state           | meaning
// ----------------+-------------------------------------------------------
// ST_IDLE         | line released, waiting for start
// ST_START_LOW    | host drives line low for START_LOW_US
// ST_RELEASE      | line released, settle RELEASE_US
// ST_WAIT_RESP_LOW| wait for sensor response falling edge
// ST_WAIT_RESP_HIGH| wait for end of sensor response low (rise)
// ST_WAIT_RESP_END| wait for end of sensor response high (fall)
// ST_WAIT_BIT_HIGH| bit low phase, wait for rise
// ST_MEASURE      | bit high phase, timer measures its width
// ST_CHECK        | verify checksum, publish or flag error
module dht11_controller
    import dht11_pkg::*;
#(
    parameter int CLK_HZ        = DEF_CLK_HZ,
    parameter int START_LOW_US  = DEF_START_LOW_US,
    parameter int RELEASE_US    = DEF_RELEASE_US,
    parameter int BIT_THRESH_US = DEF_BIT_THRESH_US,
    parameter int TIMEOUT_US    = DEF_TIMEOUT_US
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    inout  wire               dht_io,
    output logic [DATA_W-1:0] dht_data,
    output logic              valid,
    output logic              busy,
    output logic              error
);

    // The timer saturates at the largest limit any state compares against,
    // so the long start pulse count stays reachable while still never wrapping.
    localparam int TIMER_MAX = max_int(max_int(START_LOW_US, TIMEOUT_US),
                                       max_int(RELEASE_US, BIT_THRESH_US));
    localparam int TW = $clog2(TIMER_MAX + 1);

    localparam logic [TW-1:0] T_START   = TW'(START_LOW_US);
    localparam logic [TW-1:0] T_RELEASE = TW'(RELEASE_US);
    localparam logic [TW-1:0] T_THRESH  = TW'(BIT_THRESH_US);
    localparam logic [TW-1:0] T_TIMEOUT = TW'(TIMEOUT_US);
    localparam logic [TW-1:0] T_MAX     = TW'(TIMER_MAX);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(FRAME_W - 1);

    state_e               state_q, state_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [FRAME_W-1:0]   sr_q, sr_d;
    logic [DATA_W-1:0]    data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 error_q, error_d;

    logic sync1_q, sync2_q, prev_q;
    logic rise, fall, tick, timed_out;

    tick_gen_us #(
        .CLK_HZ (CLK_HZ)
    ) u_tick (
        .clk_i  (clk),
        .rst_ni (reset),
        .tick_o (tick)
    );

    // Synchronizer resets to the released (pulled-up) level so no edge is
    // seen when leaving reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= dht_io;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign rise      =  sync2_q & ~prev_q;
    assign fall      = ~sync2_q &  prev_q;
    assign timed_out = (timer_q == T_TIMEOUT);

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        sr_d      = sr_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        error_d   = error_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_START_LOW;
                    error_d   = 1'b0;
                    bit_cnt_d = '0;
                end
            end
            ST_START_LOW: begin
                if (timer_q == T_START) state_d = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (timer_q == T_RELEASE) state_d = ST_WAIT_RESP_LOW;
            end
            ST_WAIT_RESP_LOW: begin
                if (fall) begin
                    state_d = ST_WAIT_RESP_HIGH;
                end else if (timed_out) begin
                    state_d = ST_IDLE;
                    error_d = 1'b1;
                end
            end
            ST_WAIT_RESP_HIGH: begin
                if (rise) begin
                    state_d = ST_WAIT_RESP_END;
                end else if (timed_out) begin
                    state_d = ST_IDLE;
                    error_d = 1'b1;
                end
            end
            ST_WAIT_RESP_END: begin
                if (fall) begin
                    state_d = ST_WAIT_BIT_HIGH;
                end else if (timed_out) begin
                    state_d = ST_IDLE;
                    error_d = 1'b1;
                end
            end
            ST_WAIT_BIT_HIGH: begin
                if (rise) begin
                    state_d = ST_MEASURE;
                end else if (timed_out) begin
                    state_d = ST_IDLE;
                    error_d = 1'b1;
                end
            end
            ST_MEASURE: begin
                if (fall) begin
                    // Rise and fall share the same detection latency, so the
                    // timer value here is the high time in whole microseconds.
                    sr_d      = {sr_q[FRAME_W-2:0], (timer_q > T_THRESH)};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    state_d   = (bit_cnt_q == LAST_BIT) ? ST_CHECK : ST_WAIT_BIT_HIGH;
                end else if (timed_out) begin
                    state_d = ST_IDLE;
                    error_d = 1'b1;
                end
            end
            ST_CHECK: begin
                state_d = ST_IDLE;
                if (checksum_ok(sr_q)) begin
                    data_d  = sr_q[FRAME_W-1:FRAME_W-DATA_W];
                    valid_d = 1'b1;
                end else begin
                    error_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Timer restarts on every state change and stays parked at 0 in IDLE.
    always_comb begin
        timer_d = timer_q;
        if ((state_d != state_q) || (state_q == ST_IDLE)) begin
            timer_d = '0;
        end else if (tick && (timer_q != T_MAX)) begin
            timer_d = timer_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            timer_q   <= '0;
            bit_cnt_q <= '0;
            sr_q      <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_cnt_q <= bit_cnt_d;
            sr_q      <= sr_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            error_q   <= error_d;
        end
    end

    assign dht_io   = (state_q == ST_START_LOW) ? 1'b0 : 1'bz;
    assign dht_data = data_q;
    assign valid    = valid_q;
    assign busy     = (state_q != ST_IDLE);
    assign error    = error_q;

endmodule

// File: tb/tb_dht11_controller.sv
module tb_dht11_controller;

    localparam int CLK_HZ        = 2_000_000;
    localparam int DIV           = CLK_HZ / 1_000_000;
    localparam int START_LOW_US  = 200;
    localparam int RELEASE_US    = 30;
    localparam int BIT_THRESH_US = 40;
    localparam int TIMEOUT_US    = 1_000;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        sens_low;
    wire         dht_line;
    logic [31:0] dht_data;
    logic        valid;
    logic        busy;
    logic        error;

    int n_checks = 0;
    int n_errors = 0;

    pullup (dht_line);
    assign dht_line = sens_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    dht11_controller #(
        .CLK_HZ        (CLK_HZ),
        .START_LOW_US  (START_LOW_US),
        .RELEASE_US    (RELEASE_US),
        .BIT_THRESH_US (BIT_THRESH_US),
        .TIMEOUT_US    (TIMEOUT_US)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .dht_io   (dht_line),
        .dht_data (dht_data),
        .valid    (valid),
        .busy     (busy),
        .error    (error)
    );

    typedef struct {
        logic [39:0] frame;
        int          zero_us;
        bit          poke;
        bit          exp_valid;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[4];

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int v, input int lo, input int hi);
        n_checks++;
        if (v < lo || v > hi) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, v, lo, hi);
        end
    endtask

    // Reference model: the sensor's bit is 1 exactly when its high time
    // exceeds the threshold; the frame is the MSB-first string of those bits.
    function automatic longint model_decode(input int hi[40]);
        longint v;
        v = 0;
        for (int i = 0; i < 40; i++) v = v * 2 + ((hi[i] > BIT_THRESH_US) ? 1 : 0);
        return v;
    endfunction

    function automatic bit model_sum_ok(input longint v);
        int s;
        s = 0;
        for (int b = 1; b <= 4; b++) s += int'((v >> (8 * b)) & 255);
        return (s % 256) == int'(v & 255);
    endfunction

    // Host start + sensor reply with the given per-bit high times (us).
    task automatic run_frame(input int hi[40], input bit poke,
                             output int vcnt, output bit err_seen,
                             output logic [31:0] data_at_valid, output bit busy_at_valid);
        int n;
        check("idle_line_released", dht_line, 1'b1);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        check("start_busy", busy, 1'b1);
        check("start_drive_low", dht_line, 1'b0);
        check("start_clears_error", error, 1'b0);
        n = 1;
        while (dht_line === 1'b0 && n < 2 * START_LOW_US * DIV) begin
            cyc(1);
            n++;
        end
        check_range("start_low_cycles", n, START_LOW_US * DIV - 2, START_LOW_US * DIV + 3);

        cyc(40 * DIV);
        sens_low = 1'b1; cyc(20 * DIV);
        sens_low = 1'b0; cyc(20 * DIV);
        for (int i = 0; i < 40; i++) begin
            sens_low = 1'b1; cyc(10 * DIV);
            sens_low = 1'b0;
            if (poke && i == 20) begin
                cyc(10);
                start = 1'b1; cyc(1); start = 1'b0;
                check("busy_during_measure", busy, 1'b1);
                cyc(hi[i] * DIV - 11);
            end else begin
                cyc(hi[i] * DIV);
            end
        end
        sens_low = 1'b1;
        vcnt = 0;
        err_seen = 1'b0;
        data_at_valid = '0;
        busy_at_valid = 1'b1;
        for (int k = 0; k < 60; k++) begin
            cyc(1);
            if (k == 19) sens_low = 1'b0;
            if (valid) begin
                if (vcnt == 0) begin
                    data_at_valid = dht_data;
                    busy_at_valid = busy;
                end
                vcnt++;
            end
            if (error) err_seen = 1'b1;
        end
    endtask

    task automatic verify_frame(input string tag, input bit exp_valid, input logic [31:0] exp_data,
                                input int vcnt, input bit err_seen,
                                input logic [31:0] dv, input bit bv);
        check({tag, "_valid_pulses"}, vcnt, exp_valid ? 1 : 0);
        check({tag, "_error"}, err_seen, !exp_valid);
        check({tag, "_error_held"}, error, !exp_valid);
        check({tag, "_dht_data"}, dht_data, exp_data);
        check({tag, "_idle"}, busy, 1'b0);
        if (exp_valid) begin
            check({tag, "_data_at_valid"}, dv, exp_data);
            check({tag, "_busy_falls_with_valid"}, bv, 1'b0);
        end
    endtask

    function automatic void make_hi(input logic [39:0] fr, input int zero_us, output int hi[40]);
        for (int i = 0; i < 40; i++) hi[i] = fr[39 - i] ? 70 : zero_us;
    endfunction

    initial begin
        int hi[40];
        int vcnt, n;
        bit err_seen, bv;
        logic [31:0] dv;
        logic [31:0] ref_data;
        logic [39:0] fr;
        longint mv;
        bit good;
        int a, b, c, d, cs;

        vecs[0] = '{40'h2D_00_17_00_45, 26, 1'b0, 1'b0, 32'h0000_0000};
        vecs[1] = '{40'h2D_00_17_00_44, 26, 1'b0, 1'b1, 32'h2D00_1700};
        vecs[2] = '{40'h32_00_1E_00_50, 40, 1'b0, 1'b1, 32'h3200_1E00};
        vecs[3] = '{40'h3C_00_19_00_55, 26, 1'b1, 1'b1, 32'h3C00_1900};

        reset = 1'b0;
        start = 1'b0;
        sens_low = 1'b0;
        ref_data = '0;
        cyc(3);
        check("rst_busy", busy, 1'b0);
        check("rst_valid", valid, 1'b0);
        check("rst_error", error, 1'b0);
        check("rst_data", dht_data, 32'h0);
        check("rst_line", dht_line, 1'b1);
        reset = 1'b1;
        cyc(2);

        // No sensor reply: timeout counted from entry into the response wait.
        start = 1'b1; cyc(1); start = 1'b0;
        n = 0;
        while (dht_line === 1'b0 && n < 4 * START_LOW_US * DIV) begin cyc(1); n++; end
        n = 0;
        while (!error && n < 4 * TIMEOUT_US * DIV) begin cyc(1); n++; end
        check_range("timeout_latency", n, (RELEASE_US + TIMEOUT_US) * DIV - 4,
                    (RELEASE_US + TIMEOUT_US) * DIV + 4);
        check("timeout_idle", busy, 1'b0);
        check("timeout_no_valid", valid, 1'b0);
        check("timeout_data_kept", dht_data, ref_data);
        cyc(5);

        for (int v = 0; v < 4; v++) begin
            make_hi(vecs[v].frame, vecs[v].zero_us, hi);
            run_frame(hi, vecs[v].poke, vcnt, err_seen, dv, bv);
            verify_frame($sformatf("vec%0d", v), vecs[v].exp_valid, vecs[v].exp_data,
                         vcnt, err_seen, dv, bv);
            if (vecs[v].exp_valid) ref_data = vecs[v].exp_data;
            cyc(20);
        end

        for (int r = 0; r < 4; r++) begin
            a = $urandom_range(10, 95); b = $urandom_range(0, 9);
            c = $urandom_range(0, 50);  d = $urandom_range(0, 9);
            cs = (a + b + c + d) % 256;
            if ($urandom_range(0, 2) == 0) cs = (cs + $urandom_range(1, 255)) % 256;
            fr = {8'(a), 8'(b), 8'(c), 8'(d), 8'(cs)};
            for (int i = 0; i < 40; i++)
                hi[i] = fr[39 - i] ? $urandom_range(45, 75) : $urandom_range(20, 35);
            mv = model_decode(hi);
            good = model_sum_ok(mv);
            if (good) ref_data = 32'(mv >> 8);
            run_frame(hi, 1'b0, vcnt, err_seen, dv, bv);
            verify_frame($sformatf("rnd%0d", r), good, ref_data, vcnt, err_seen, dv, bv);
            cyc(20);
        end

        // Reset in the middle of the start pulse.
        start = 1'b1; cyc(1); start = 1'b0;
        cyc(START_LOW_US * DIV / 2);
        check("pre_reset_drive_low", dht_line, 1'b0);
        reset = 1'b0;
        cyc(1);
        check("midrst_line", dht_line, 1'b1);
        check("midrst_busy", busy, 1'b0);
        check("midrst_valid", valid, 1'b0);
        check("midrst_error", error, 1'b0);
        check("midrst_data", dht_data, 32'h0);
        reset = 1'b1;
        ref_data = '0;
        cyc(5);

        make_hi(40'h2D_00_17_00_44, 26, hi);
        mv = model_decode(hi);
        good = model_sum_ok(mv);
        if (good) ref_data = 32'(mv >> 8);
        run_frame(hi, 1'b0, vcnt, err_seen, dv, bv);
        verify_frame("post_reset", good, ref_data, vcnt, err_seen, dv, bv);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #950_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1);
    end

endmodule
